// File: rtl/muldiv_unit_pkg.sv
// Shared types for the 8051 MUL AB / DIV AB execution unit.
// State encodings live here so the decoder and integrator see the same values.
package muldiv_unit_pkg;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  function automatic logic md_active(input md_state_e s);
    return (s != MD_IDLE);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MUL AB / DIV AB unit: one operand bit per cycle over a shared shift register,
// results returned through single-cycle ACC / B / PSW write strobes.
//
// state   | meaning
// --------+-----------------------------------------------------------
// MD_IDLE | waiting for start_mul / start_div, operands captured on start
// MD_MUL  | shift-add, one multiplier bit per cycle, LSB first
// MD_DIV  | restoring division, one quotient bit per cycle, MSB first
// MD_DONE | one-cycle result / flag strobe, then back to idle
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mul,
  input  logic             start_div,
  input  logic [WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             acc_wr,
  output logic [WIDTH-1:0] acc_out,
  output logic             b_wr,
  output logic [WIDTH-1:0] b_out,
  output logic             psw_wr,
  output logic             cy_out,
  output logic             ov_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  md_state_e          state, state_n;
  // MUL: full product. DIV: {remainder, dividend shifting into quotient}.
  logic [2*WIDTH-1:0] work, work_n;
  logic [WIDTH-1:0]   opnd, opnd_n;
  logic               op_div, op_div_n;
  logic               div0, div0_n;
  logic [CW-1:0]      cnt, cnt_n;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH:0]     div_diff;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= MD_IDLE;
      work   <= '0;
      opnd   <= '0;
      op_div <= 1'b0;
      div0   <= 1'b0;
      cnt    <= '0;
    end else begin
      state  <= state_n;
      work   <= work_n;
      opnd   <= opnd_n;
      op_div <= op_div_n;
      div0   <= div0_n;
      cnt    <= cnt_n;
    end
  end

  always_comb begin
    mul_sum   = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, opnd} : '0);
    div_trial = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
    // Borrow out of the W+1-bit subtract means the trial remainder is below the divisor.
    div_diff  = div_trial - {1'b0, opnd};
  end

  always_comb begin
    state_n  = state;
    work_n   = work;
    opnd_n   = opnd;
    op_div_n = op_div;
    div0_n   = div0;
    cnt_n    = cnt;
    case (state)
      MD_IDLE: begin
        if (start_mul) begin
          state_n  = MD_MUL;
          work_n   = {{WIDTH{1'b0}}, b_in};
          opnd_n   = acc_in;
          op_div_n = 1'b0;
          div0_n   = 1'b0;
          cnt_n    = '0;
        end else if (start_div) begin
          work_n   = {{WIDTH{1'b0}}, acc_in};
          opnd_n   = b_in;
          op_div_n = 1'b1;
          cnt_n    = '0;
          if (b_in == '0) begin
            state_n = MD_DONE;
            div0_n  = 1'b1;
          end else begin
            state_n = MD_DIV;
            div0_n  = 1'b0;
          end
        end
      end
      MD_MUL: begin
        work_n = {mul_sum, work[WIDTH-1:1]};
        cnt_n  = cnt + 1'b1;
        if (cnt == CNT_LAST) state_n = MD_DONE;
      end
      MD_DIV: begin
        if (!div_diff[WIDTH])
          work_n = {div_diff[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
        else
          work_n = {div_trial[WIDTH-1:0], work[WIDTH-2:0], 1'b0};
        cnt_n = cnt + 1'b1;
        if (cnt == CNT_LAST) state_n = MD_DONE;
      end
      MD_DONE: state_n = MD_IDLE;
      default: state_n = MD_IDLE;
    endcase
  end

  always_comb begin
    busy    = md_active(state);
    done    = 1'b0;
    acc_wr  = 1'b0;
    b_wr    = 1'b0;
    psw_wr  = 1'b0;
    acc_out = '0;
    b_out   = '0;
    cy_out  = 1'b0;
    ov_out  = 1'b0;
    if (state == MD_DONE) begin
      done   = 1'b1;
      psw_wr = 1'b1;
      if (div0) begin
        ov_out = 1'b1;
      end else begin
        acc_wr  = 1'b1;
        b_wr    = 1'b1;
        acc_out = work[WIDTH-1:0];
        b_out   = work[2*WIDTH-1:WIDTH];
        ov_out  = op_div ? 1'b0 : |work[2*WIDTH-1:WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed cases plus random MUL/DIV traffic
// checked against plain integer arithmetic.
module tb_muldiv_unit;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start_mul = 1'b0;
  logic       start_div = 1'b0;
  logic [7:0] acc_in = 8'h00;
  logic [7:0] b_in = 8'h00;
  logic       busy, done, acc_wr, b_wr, psw_wr, cy_out, ov_out;
  logic [7:0] acc_out, b_out;

  muldiv_unit #(.WIDTH(8)) dut (
    .clock(clock), .reset(reset), .start_mul(start_mul), .start_div(start_div),
    .acc_in(acc_in), .b_in(b_in), .busy(busy), .done(done),
    .acc_wr(acc_wr), .acc_out(acc_out), .b_wr(b_wr), .b_out(b_out),
    .psw_wr(psw_wr), .cy_out(cy_out), .ov_out(ov_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] acc;
    logic [7:0] b;
    logic       ov;
    logic       wr;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic prev_done = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clock) begin
    exp_t e;
    if (done) begin
      chk("done_one_cycle", prev_done, 1'b0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 1'b1, 1'b0);
      end else begin
        e = sb.pop_front();
        chk("latency", cyc, e.due);
        chk("acc_wr", acc_wr, e.wr);
        chk("b_wr", b_wr, e.wr);
        chk("psw_wr", psw_wr, 1'b1);
        chk("cy_out", cy_out, 1'b0);
        chk("ov_out", ov_out, e.ov);
        if (e.wr) begin
          chk("acc_out", acc_out, e.acc);
          chk("b_out", b_out, e.b);
        end
      end
    end else begin
      chk("idle_outputs", {acc_out, b_out, acc_wr, b_wr, psw_wr, cy_out, ov_out}, '0);
      if (sb.size() > 0 && cyc > sb[0].due) begin
        chk("done_late", cyc, sb[0].due);
        void'(sb.pop_front());
      end
    end
    prev_done <= done;
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 40) chk("idle_timeout", busy, 1'b0);
  endtask

  // Drives a start for one cycle right after an edge; expected result comes from integer arithmetic.
  task automatic issue(input logic m, input logic d, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    logic [15:0] p;
    wait_idle();
    start_mul = m;
    start_div = d;
    acc_in    = a;
    b_in      = b;
    e.due = cyc + 1;
    e.wr  = 1'b1;
    e.ov  = 1'b0;
    if (m) begin
      p = 16'(a) * 16'(b);
      e.acc = p[7:0];
      e.b   = p[15:8];
      e.ov  = (p > 16'd255);
      e.due = e.due + 8;
      sb.push_back(e);
    end else if (d) begin
      if (b == 8'h00) begin
        e.acc = 8'h00;
        e.b   = 8'h00;
        e.wr  = 1'b0;
        e.ov  = 1'b1;
      end else begin
        e.acc = a / b;
        e.b   = a % b;
        e.due = e.due + 8;
      end
      sb.push_back(e);
    end
    @(posedge clock); #1;
    if (m || d) chk("busy_after_start", busy, 1'b1);
    start_mul = 1'b0;
    start_div = 1'b0;
    acc_in    = 8'($urandom);
    b_in      = 8'($urandom);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    reset = 1'b1;
    @(posedge clock); #1;

    issue(1, 0, 8'h50, 8'hA0);
    issue(1, 0, 8'h0C, 8'h0A);
    issue(1, 0, 8'hFF, 8'hFF);
    issue(0, 1, 8'hFB, 8'h12);
    issue(0, 1, 8'h07, 8'h09);
    issue(0, 1, 8'h33, 8'h00);
    issue(1, 1, 8'h11, 8'h05);
    issue(0, 1, 8'h80, 8'h01);
    issue(1, 0, 8'h00, 8'h7F);

    // Start attempts while busy must be ignored; the monitor flags any extra done.
    issue(1, 0, 8'h23, 8'h45);
    @(posedge clock); #1;
    start_div = 1'b1;
    acc_in = 8'h99;
    b_in   = 8'h03;
    @(posedge clock); #1;
    start_div = 1'b0;
    start_mul = 1'b1;
    @(posedge clock); #1;
    start_mul = 1'b0;

    // Reset in the middle of a division aborts it with no strobes.
    issue(0, 1, 8'hFB, 8'h12);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_strobes", {acc_wr, b_wr, psw_wr, acc_out, b_out}, '0);
    sb.delete();
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b1;
    @(posedge clock); #1;
    issue(1, 0, 8'h02, 8'h03);

    for (int i = 0; i < 60; i++) begin
      logic [7:0] a, b;
      int sel;
      a   = 8'($urandom);
      b   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      sel = $urandom_range(0, 3);
      issue(sel == 0 || sel == 3, sel == 1 || sel == 3, a, b);
    end

    wait_idle();
    repeat (4) @(posedge clock);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
